// File: rtl/fetch_mem_bridge_if.sv
// fetch_mem_bridge_if: core fetch port and memory port of the fetch bridge
interface fetch_mem_bridge_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
);
    logic                    fetch_read;
    logic [ADDRESS_BITS-1:0] fetch_address_in;
    logic                    flush;
    logic                    fetch_ready;
    logic                    fetch_valid;
    logic [DATA_WIDTH-1:0]   fetch_data_out;
    logic [ADDRESS_BITS-1:0] fetch_address_out;
    logic                    fetch_fault;
    logic                    mem_req;
    logic [ADDRESS_BITS-1:0] mem_addr;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        input  fetch_read, fetch_address_in, flush, mem_gnt, mem_rvalid, mem_rdata,
        output fetch_ready, fetch_valid, fetch_data_out, fetch_address_out, fetch_fault,
               mem_req, mem_addr
    );

    modport slave (
        output fetch_read, fetch_address_in, flush, mem_gnt, mem_rvalid, mem_rdata,
        input  fetch_ready, fetch_valid, fetch_data_out, fetch_address_out, fetch_fault,
               mem_req, mem_addr
    );
endinterface

// File: rtl/fetch_mem_bridge.sv
// fetch_mem_bridge: single-outstanding instruction fetch bridge onto a req/gnt/rvalid memory port
module fetch_mem_bridge #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int TIMEOUT      = 64
) (
    input logic                clock,
    input logic                reset,
    fetch_mem_bridge_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t        state, state_d;
    logic          flush_seen;
    logic [CW-1:0] cnt;
    logic          bad, hit, timeout, respond;

    assign bad     = state == IDLE && bus.fetch_read && bus.fetch_address_in[1:0] != 2'b00;
    assign hit     = state == WAIT && bus.mem_rvalid && !bus.flush;
    assign timeout = state == WAIT && !bus.mem_rvalid && !bus.flush && cnt == CW'(TIMEOUT - 1);
    assign respond = bad || hit || timeout;

    assign bus.fetch_ready = state == IDLE;
    assign bus.mem_req     = state == REQ;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = bus.fetch_read && bus.fetch_address_in[1:0] == 2'b00 ? REQ : IDLE;
            REQ:     state_d = !bus.mem_gnt ? REQ : (flush_seen || bus.flush) ? DRAIN : WAIT;
            WAIT:    state_d = bus.mem_rvalid ? IDLE : (bus.flush || timeout) ? DRAIN : WAIT;
            DRAIN:   state_d = bus.mem_rvalid ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // mem_addr doubles as the latched fetch address; only aligned addresses are ever captured
    always_ff @(posedge clock) begin
        if (!reset) begin
            state                 <= IDLE;
            flush_seen            <= 1'b0;
            cnt                   <= '0;
            bus.mem_addr          <= '0;
            bus.fetch_valid       <= 1'b0;
            bus.fetch_fault       <= 1'b0;
            bus.fetch_data_out    <= '0;
            bus.fetch_address_out <= '0;
        end else begin
            state           <= state_d;
            flush_seen      <= state == REQ && state_d == REQ && (flush_seen || bus.flush);
            cnt             <= state == WAIT ? cnt + 1'b1 : '0;
            bus.fetch_valid <= respond;
            if (state == IDLE && state_d == REQ)
                bus.mem_addr <= bus.fetch_address_in;
            if (respond) begin
                bus.fetch_fault       <= !hit;
                bus.fetch_data_out    <= hit ? bus.mem_rdata : NOP;
                bus.fetch_address_out <= bad ? bus.fetch_address_in : bus.mem_addr;
            end
        end
    end
endmodule
